// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Display back-end for the four-digit clock. Takes four BCD digits plus
// per-digit dot and blink controls and time-multiplexes them onto a single
// 8-bit segment bus and four one-hot digit enables. Each digit slot begins
// with a short all-off blanking interval to suppress ghosting. Inputs are
// captured once per scan frame so that a frame is always drawn from one
// coherent set of values. A slow blink phase, derived from the frame count,
// darkens the masked digits on alternate blink half-periods.
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  all-off cycles at the start of each slot
//                 (1 <= BLANK_CYCLES < REFRESH_DIV)
//   BLINK_FRAMES  full scan frames per blink half-period (>= 1)
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset_n     asynchronous active-low reset
//   i_Enable      display enable; low holds the scan at slot 0, outputs off
//   i_Digits_Bcd  four BCD digits, [3:0] is digit 0, [15:12] is digit 3
//   i_Dots        decimal point per digit, active high
//   i_Blink_Mask  digits that blink, active high
//   o_Segments    {dp,g,f,e,d,c,b,a}, active high, registered
//   o_Digits      one-hot digit enable, bit n selects digit n, registered
//   o_Frame_Tick  one-cycle pulse the cycle after a new snapshot is loaded
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, slot 3 stays dark (dot included)
//                          whenever the captured digit 3 is zero.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Enable,
    input  logic [15:0] i_Digits_Bcd,
    input  logic [3:0]  i_Dots,
    input  logic [3:0]  i_Blink_Mask,
    output logic [7:0]  o_Segments,
    output logic [3:0]  o_Digits,
    output logic        o_Frame_Tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc;
    logic [1:0]    slot;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [15:0]   snap_bcd;
    logic [3:0]    snap_dots;
    logic [3:0]    snap_mask;

    logic          frame_start;
    logic          lead_blank;
    logic          show;
    logic [3:0]    bcd_cur;

    // Seven-segment pattern in gfedcba order; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    assign frame_start = (presc == '0) && (slot == 2'd0);
    assign bcd_cur     = snap_bcd[{slot, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_blank = (slot == 2'd3) && (snap_bcd[15:12] == 4'd0);
`else
    assign lead_blank = 1'b0;
`endif

    // A digit is lit only after the anti-ghost interval, and only when it is
    // neither in the dark blink half-period nor a suppressed leading zero.
    assign show = (presc >= P_BLANK) && !(blink_phase && snap_mask[slot]) && !lead_blank;

    // Scan counters, snapshot and registered outputs. Disabling parks the
    // scan at the start of a frame so re-enabling begins with a blanking
    // interval and a fresh snapshot; the blink phase survives a disable.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            presc        <= '0;
            slot         <= 2'd0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            snap_bcd     <= '0;
            snap_dots    <= '0;
            snap_mask    <= '0;
            o_Segments   <= '0;
            o_Digits     <= '0;
            o_Frame_Tick <= 1'b0;
        end else if (!i_Enable) begin
            presc        <= '0;
            slot         <= 2'd0;
            frame_cnt    <= '0;
            o_Segments   <= '0;
            o_Digits     <= '0;
            o_Frame_Tick <= 1'b0;
        end else begin
            o_Frame_Tick <= frame_start;
            if (frame_start) begin
                snap_bcd  <= i_Digits_Bcd;
                snap_dots <= i_Dots;
                snap_mask <= i_Blink_Mask;
            end

            if (show) begin
                o_Digits   <= 4'b0001 << slot;
                o_Segments <= {snap_dots[slot], decode(bcd_cur)};
            end else begin
                o_Digits   <= '0;
                o_Segments <= '0;
            end

            if (presc == P_LAST) begin
                presc <= '0;
                slot  <= slot + 2'd1;
                if (slot == 2'd3) begin
                    if (frame_cnt == F_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=8,
// BLANK_CYCLES=2, BLINK_FRAMES=2. The reference model tracks only the number
// of enabled cycles since the scan last restarted; slot, blanking, frame and
// blink phase are derived from that count with plain arithmetic.
// Define LEADING_ZERO_BLANK_EN for both files to exercise the build option.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = RD * 4;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Enable = 1'b0;
    logic [15:0] i_Digits_Bcd = '0;
    logic [3:0]  i_Dots = '0;
    logic [3:0]  i_Blink_Mask = '0;
    logic [7:0]  o_Segments;
    logic [3:0]  o_Digits;
    logic        o_Frame_Tick;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int         n = 0;
    int         phase_base = 0;
    logic [3:0] m_bcd [4];
    logic [3:0] m_dot;
    logic [3:0] m_mask;

    logic [6:0] seg_table [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

    seven_seg_scanner #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Enable    (i_Enable),
        .i_Digits_Bcd(i_Digits_Bcd),
        .i_Dots      (i_Dots),
        .i_Blink_Mask(i_Blink_Mask),
        .o_Segments  (o_Segments),
        .o_Digits    (o_Digits),
        .o_Frame_Tick(o_Frame_Tick)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic model_reset();
        n = 0;
        phase_base = 0;
        for (int i = 0; i < 4; i++) m_bcd[i] = 4'd0;
        m_dot = '0;
        m_mask = '0;
    endtask

    // Predicts the outputs that the coming clock edge will produce from the
    // present inputs, advances the model, then waits until #1 after the edge.
    task automatic advance(output logic [7:0] e_seg, output logic [3:0] e_dig,
                           output logic e_tick);
        int p, s, ph;
        logic vis;
        e_seg = '0;
        e_dig = '0;
        e_tick = 1'b0;
        if (!i_Enable) begin
            phase_base = phase_base ^ (((n / FRAME) / BF) % 2);
            n = 0;
        end else begin
            p  = n % RD;
            s  = (n / RD) % 4;
            ph = phase_base ^ (((n / FRAME) / BF) % 2);
            vis = (p >= BC) && !(ph == 1 && m_mask[s]);
`ifdef LEADING_ZERO_BLANK_EN
            if (s == 3 && m_bcd[3] == 4'd0) vis = 1'b0;
`endif
            if (vis) begin
                e_dig = 4'b0001 << s;
                e_seg = {m_dot[s], seg_table[m_bcd[s]]};
            end
            e_tick = (n % FRAME == 0);
            if (n % FRAME == 0) begin
                for (int i = 0; i < 4; i++) m_bcd[i] = i_Digits_Bcd[i*4 +: 4];
                m_dot  = i_Dots;
                m_mask = i_Blink_Mask;
            end
            n++;
        end
        @(posedge i_Clock);
        #1;
    endtask

    task automatic test_reset();
        i_Reset_n = 1'b0;
        #12;
        checks++;
        if ({o_Segments, o_Digits, o_Frame_Tick} !== 13'd0)
            $display("[TB] FAIL reset_outputs: got seg=%b dig=%b tick=%b, want all 0",
                     o_Segments, o_Digits, o_Frame_Tick);
        else passes++;
        @(posedge i_Clock);
        #1;
        i_Reset_n = 1'b1;
        model_reset();
        checks++;
        if ({o_Segments, o_Digits, o_Frame_Tick} !== 13'd0)
            $display("[TB] FAIL reset_release: got seg=%b dig=%b tick=%b, want all 0",
                     o_Segments, o_Digits, o_Frame_Tick);
        else passes++;
    endtask

    task automatic test_scan_1234();
        logic [7:0] es; logic [3:0] ed; logic et;
        int ticks = 0;
        i_Digits_Bcd = 16'h1234;
        i_Dots = 4'b0000;
        i_Blink_Mask = 4'b0000;
        i_Enable = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            advance(es, ed, et);
            ticks += int'(o_Frame_Tick);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL scan_1234 cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        checks++;
        if (ticks !== 2)
            $display("[TB] FAIL scan_1234_ticks: got %0d want 2", ticks);
        else passes++;
    endtask

    task automatic test_dots();
        logic [7:0] es; logic [3:0] ed; logic et;
        int stray = 0;
        int seen = 0;
        i_Dots = 4'b0100;
        for (int c = 0; c < 3 * FRAME; c++) begin
            advance(es, ed, et);
            if (c >= FRAME) begin
                if (o_Segments[7] && o_Digits != 4'b0100) stray++;
                if (o_Segments[7] && o_Digits == 4'b0100) seen++;
            end
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL dots cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        checks++;
        if (stray !== 0 || seen !== 2 * (RD - BC))
            $display("[TB] FAIL dots_slot: got stray=%0d seen=%0d want 0 and %0d",
                     stray, seen, 2 * (RD - BC));
        else passes++;
        i_Dots = 4'b0000;
    endtask

    task automatic test_mid_frame_change();
        logic [7:0] es; logic [3:0] ed; logic et;
        int lead = 2 + int'($urandom_range(0, FRAME - 4));
        i_Digits_Bcd = 16'h1234;
        for (int c = 0; c < FRAME; c++) begin
            if (n % FRAME == lead) i_Digits_Bcd = 16'h5678;
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL mid_change cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL mid_change_after cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
    endtask

    task automatic test_blink();
        logic [7:0] es; logic [3:0] ed; logic et;
        int lit0 = 0;
        int lit2 = 0;
        i_Digits_Bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        i_Blink_Mask = 4'b0011;
        for (int c = 0; c < 6 * FRAME; c++) begin
            advance(es, ed, et);
            if (o_Digits[0]) lit0++;
            if (o_Digits[2]) lit2++;
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL blink cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        checks++;
        if (lit0 >= lit2 || lit2 == 0)
            $display("[TB] FAIL blink_duty: got lit0=%0d lit2=%0d want lit0<lit2",
                     lit0, lit2);
        else passes++;
        i_Blink_Mask = 4'b0000;
    endtask

    task automatic test_dash_and_enable();
        logic [7:0] es; logic [3:0] ed; logic et;
        int dash = 0;
        int off_at = 3 + int'($urandom_range(0, RD - 4));
        i_Digits_Bcd = 16'h1A34;
        for (int c = 0; c < 2 * FRAME + RD + off_at; c++) begin
            advance(es, ed, et);
            if (o_Digits == 4'b0100 && o_Segments[6:0] == 7'b1000000) dash++;
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL dash cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        checks++;
        if (dash == 0)
            $display("[TB] FAIL dash_seen: got %0d dash cycles want >0", dash);
        else passes++;
        i_Enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== 13'd0)
                $display("[TB] FAIL disabled cyc %0d: got %b/%b/%b want all 0",
                         c, o_Segments, o_Digits, o_Frame_Tick);
            else passes++;
        end
        i_Enable = 1'b1;
        for (int c = 0; c < FRAME + 4; c++) begin
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL reenable cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] es; logic [3:0] ed; logic et;
        int d3 = 0;
        i_Digits_Bcd = 16'h0930;
        for (int c = 0; c < 3 * FRAME; c++) begin
            advance(es, ed, et);
            if (c >= FRAME && o_Digits[3]) d3++;
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL lead_zero cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (d3 !== 0)
            $display("[TB] FAIL lead_zero_digit3: got %0d lit cycles want 0", d3);
        else passes++;
`else
        if (d3 !== 2 * (RD - BC))
            $display("[TB] FAIL lead_zero_digit3: got %0d lit cycles want %0d",
                     d3, 2 * (RD - BC));
        else passes++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] es; logic [3:0] ed; logic et;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) i_Digits_Bcd = 16'($urandom);
            if ($urandom_range(0, 15) == 0) i_Dots = 4'($urandom);
            if ($urandom_range(0, 31) == 0) i_Blink_Mask = 4'($urandom);
            if ($urandom_range(0, 99) == 0) i_Enable = ~i_Enable;
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL random cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
        i_Enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] es; logic [3:0] ed; logic et;
        i_Digits_Bcd = 16'h8888;
        i_Blink_Mask = 4'b0000;
        for (int c = 0; c < FRAME + RD + 4; c++) advance(es, ed, et);
        #2;
        i_Reset_n = 1'b0;
        #1;
        checks++;
        if ({o_Segments, o_Digits, o_Frame_Tick} !== 13'd0)
            $display("[TB] FAIL async_reset: got %b/%b/%b want all 0",
                     o_Segments, o_Digits, o_Frame_Tick);
        else passes++;
        @(posedge i_Clock);
        @(posedge i_Clock);
        #1;
        i_Reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < FRAME + 8; c++) begin
            advance(es, ed, et);
            checks++;
            if ({o_Segments, o_Digits, o_Frame_Tick} !== {es, ed, et})
                $display("[TB] FAIL after_reset cyc %0d: got %b/%b/%b want %b/%b/%b",
                         c, o_Segments, o_Digits, o_Frame_Tick, es, ed, et);
            else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_1234();
        test_dots();
        test_mid_frame_change();
        test_blink();
        test_dash_and_enable();
        test_leading_zero();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
